// File: rtl/l2_pkg.sv
// Shared definitions for the L2 miss handler: entry layout, sequencer states
// and the address slicing used to index and tag the L2 array.
package l2_pkg;

   localparam int L2_ADDR_W  = 32;
   localparam int L2_INDEX_W = 10;
   localparam int L2_TAG_W   = 18;
   localparam int VALID_BIT  = L2_TAG_W + 1;
   localparam int DIRTY_BIT  = L2_TAG_W;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TAG_CHK = 3'd1,
      ST_WB_REQ  = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_FILL    = 3'd5,
      ST_DONE    = 3'd6
   } l2_state_e;

   function automatic logic [L2_INDEX_W-1:0] addr_index(input logic [L2_ADDR_W-1:0] addr);
      return addr[11:2];
   endfunction

   function automatic logic [L2_TAG_W-1:0] addr_tag(input logic [L2_ADDR_W-1:0] addr);
      return addr[29:12];
   endfunction

   // Memory line address; the two top bits are outside the cached region.
   function automatic logic [L2_ADDR_W-1:0] line_addr(input logic [L2_TAG_W-1:0]   tag,
                                                      input logic [L2_INDEX_W-1:0] index);
      return {2'b00, tag, index, 2'b00};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX_C = {WIDTH{1'b1}};

   // count events until saturation
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= {WIDTH{1'b0}};
      end else if (inc && (count != MAX_C)) begin
         count <= count + ONE_C;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/l2_miss_handler.sv
// Sequencer between the L2 array and main memory: tag check, dirty-victim
// writeback, line refill, fill strobe and completion pulse, plus event counters.
module l2_miss_handler
   import l2_pkg::*;
#(
   parameter int ADDR_W  = L2_ADDR_W,
   parameter int DATA_W  = 64,
   parameter int INDEX_W = L2_INDEX_W,
   parameter int TAG_W   = L2_TAG_W,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   output logic               resp_valid,
   output logic               resp_hit,
   output logic [INDEX_W-1:0] l2_index,
   input  logic [TAG_W+1:0]   l2_entry,
   input  logic [DATA_W-1:0]  l2_data,
   output logic               fill_we,
   output logic [TAG_W+1:0]   fill_entry,
   output logic [DATA_W-1:0]  fill_data,
   output logic               mem_req_valid,
   output logic               mem_req_we,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic               mem_req_ready,
   input  logic               mem_rvalid,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [CNT_W-1:0]   hit_cnt,
   output logic [CNT_W-1:0]   miss_cnt,
   output logic [CNT_W-1:0]   wb_cnt
);

   l2_state_e          state_r;
   logic [TAG_W-1:0]   tag_r;
   logic [INDEX_W-1:0] l2_index_r;
   logic               req_ready_r;
   logic               resp_valid_r;
   logic               resp_hit_r;
   logic               fill_we_r;
   logic [TAG_W+1:0]   fill_entry_r;
   logic [DATA_W-1:0]  fill_data_r;
   logic               mem_req_valid_r;
   logic               mem_req_we_r;
   logic [ADDR_W-1:0]  mem_req_addr_r;
   logic [DATA_W-1:0]  mem_wdata_r;

   logic hit_s;
   logic dirty_victim_s;
   logic hit_inc_s;
   logic miss_inc_s;
   logic wb_inc_s;

   assign hit_s          = l2_entry[VALID_BIT] && (l2_entry[TAG_W-1:0] == tag_r);
   assign dirty_victim_s = l2_entry[VALID_BIT] && l2_entry[DIRTY_BIT] && !hit_s;
   assign hit_inc_s      = (state_r == ST_TAG_CHK) && hit_s;
   assign miss_inc_s     = (state_r == ST_TAG_CHK) && !hit_s;
   assign wb_inc_s       = (state_r == ST_WB_REQ) && mem_req_ready;

   assign req_ready     = req_ready_r;
   assign resp_valid    = resp_valid_r;
   assign resp_hit      = resp_hit_r;
   assign l2_index      = l2_index_r;
   assign fill_we       = fill_we_r;
   assign fill_entry    = fill_entry_r;
   assign fill_data     = fill_data_r;
   assign mem_req_valid = mem_req_valid_r;
   assign mem_req_we    = mem_req_we_r;
   assign mem_req_addr  = mem_req_addr_r;
   assign mem_wdata     = mem_wdata_r;

   sat_counter #(.WIDTH(CNT_W)) u_hit_cnt  (.clk(clk), .rst(rst), .inc(hit_inc_s),  .count(hit_cnt));
   sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .inc(miss_inc_s), .count(miss_cnt));
   sat_counter #(.WIDTH(CNT_W)) u_wb_cnt   (.clk(clk), .rst(rst), .inc(wb_inc_s),   .count(wb_cnt));

   // sequencer state and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         tag_r           <= {TAG_W{1'b0}};
         l2_index_r      <= {INDEX_W{1'b0}};
         req_ready_r     <= 1'b0;
         resp_valid_r    <= 1'b0;
         resp_hit_r      <= 1'b0;
         fill_we_r       <= 1'b0;
         fill_entry_r    <= {(TAG_W+2){1'b0}};
         fill_data_r     <= {DATA_W{1'b0}};
         mem_req_valid_r <= 1'b0;
         mem_req_we_r    <= 1'b0;
         mem_req_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r     <= {DATA_W{1'b0}};
      end else begin
         resp_valid_r <= 1'b0;
         fill_we_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // ready rises one cycle after reset so the first accept is clean
               if (req_ready_r && req_valid) begin
                  tag_r       <= addr_tag(req_addr);
                  l2_index_r  <= addr_index(req_addr);
                  req_ready_r <= 1'b0;
                  state_r     <= ST_TAG_CHK;
               end else begin
                  req_ready_r <= 1'b1;
               end
            end
            ST_TAG_CHK: begin
               resp_hit_r <= hit_s;
               if (hit_s) begin
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_DONE;
               end else if (dirty_victim_s) begin
                  mem_req_valid_r <= 1'b1;
                  mem_req_we_r    <= 1'b1;
                  mem_req_addr_r  <= line_addr(l2_entry[TAG_W-1:0], l2_index_r);
                  mem_wdata_r     <= l2_data;
                  state_r         <= ST_WB_REQ;
               end else begin
                  mem_req_valid_r <= 1'b1;
                  mem_req_we_r    <= 1'b0;
                  mem_req_addr_r  <= line_addr(tag_r, l2_index_r);
                  state_r         <= ST_RD_REQ;
               end
            end
            ST_WB_REQ: begin
               // valid stays high straight into the read request
               if (mem_req_ready) begin
                  mem_req_we_r   <= 1'b0;
                  mem_req_addr_r <= line_addr(tag_r, l2_index_r);
                  state_r        <= ST_RD_REQ;
               end else begin
                  state_r <= ST_WB_REQ;
               end
            end
            ST_RD_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid_r <= 1'b0;
                  state_r         <= ST_RD_WAIT;
               end else begin
                  state_r <= ST_RD_REQ;
               end
            end
            ST_RD_WAIT: begin
               if (mem_rvalid) begin
                  fill_data_r  <= mem_rdata;
                  fill_entry_r <= {1'b1, 1'b0, tag_r};
                  fill_we_r    <= 1'b1;
                  state_r      <= ST_FILL;
               end else begin
                  state_r <= ST_RD_WAIT;
               end
            end
            ST_FILL: begin
               resp_valid_r <= 1'b1;
               state_r      <= ST_DONE;
            end
            ST_DONE: begin
               req_ready_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               mem_req_valid_r <= 1'b0;
               req_ready_r     <= 1'b0;
               state_r         <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_miss_handler.sv
// Randomised bench for l2_miss_handler: an L2 array and memory environment
// plus a transaction-level model predicting handshakes, fills, latency and counters.
module tb_l2_miss_handler;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int INDEX_W = 10;
   localparam int TAG_W = 18;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic               req_ready;
   logic [ADDR_W-1:0]  req_addr;
   logic               resp_valid;
   logic               resp_hit;
   logic [INDEX_W-1:0] l2_index;
   logic [TAG_W+1:0]   l2_entry;
   logic [DATA_W-1:0]  l2_data;
   logic               fill_we;
   logic [TAG_W+1:0]   fill_entry;
   logic [DATA_W-1:0]  fill_data;
   logic               mem_req_valid;
   logic               mem_req_we;
   logic [ADDR_W-1:0]  mem_req_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_req_ready;
   logic               mem_rvalid;
   logic [DATA_W-1:0]  mem_rdata;
   logic [CNT_W-1:0]   hit_cnt;
   logic [CNT_W-1:0]   miss_cnt;
   logic [CNT_W-1:0]   wb_cnt;

   // L2 array contents as seen by the environment
   logic               l2_v    [1024];
   logic               l2_d    [1024];
   logic [TAG_W-1:0]   l2_t    [1024];
   logic [DATA_W-1:0]  l2_line [1024];

   int checks = 0;
   int errors = 0;
   int m_hit = 0;
   int m_miss = 0;
   int m_wb = 0;

   assign l2_entry = {l2_v[l2_index], l2_d[l2_index], l2_t[l2_index]};
   assign l2_data  = l2_line[l2_index];

   always #5 clk = ~clk;

   l2_miss_handler #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_hit(resp_hit),
      .l2_index(l2_index), .l2_entry(l2_entry), .l2_data(l2_data),
      .fill_we(fill_we), .fill_entry(fill_entry), .fill_data(fill_data),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
      .mem_req_ready(mem_req_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sat(input int n);
      return (n > CNT_MAX) ? 64'(CNT_MAX) : 64'(n);
   endfunction

   function automatic logic [INDEX_W-1:0] pick_idx(input int k);
      case (k)
         0: return 10'h329;
         1: return 10'h000;
         2: return 10'h3FF;
         default: return 10'h155;
      endcase
   endfunction

   function automatic logic [TAG_W-1:0] pick_tag(input int k);
      case (k)
         0: return 18'h12345;
         1: return 18'h00ABC;
         2: return 18'h3FFFF;
         default: return 18'h00000;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         mem_rvalid    = 1'($urandom_range(0, 1));
         mem_rdata     = {$urandom, $urandom};
         mem_req_ready = 1'($urandom_range(0, 1));
         step();
         chk_eq("idle_fill_we", fill_we, 0);
         chk_eq("idle_resp_valid", resp_valid, 0);
         chk_eq("idle_mem_req_valid", mem_req_valid, 0);
      end
      mem_rvalid = 1'b0;
   endtask

   // One request: predict the outcome from the array, play memory, compare.
   task automatic run_req(input logic [31:0] addr, input int wb_lat, input int rd_lat,
                          input int rv_lat, input logic [63:0] rdata, input bit abort);
      logic [INDEX_W-1:0] idx = addr[11:2];
      logic [TAG_W-1:0]   tag = addr[29:12];
      bit hit = l2_v[idx] && (l2_t[idx] == tag);
      bit dirty = !hit && l2_v[idx] && l2_d[idx];
      logic [31:0] wb_addr = {2'b00, l2_t[idx], idx, 2'b00};
      logic [31:0] rd_addr = {2'b00, tag, idx, 2'b00};
      logic [63:0] wb_data = l2_line[idx];
      int exp_cyc = hit ? 2 : (dirty ? 6 + wb_lat + rd_lat + rv_lat : 5 + rd_lat + rv_lat);
      int n = 1, w = 0, hs = 0, low = 0, fills = 0, rv_wait = -1, cur_lat = 0, rd_i = 0;
      bit done = 0, aborted = 0, prev_pending = 0;
      logic prev_we = 1'b0;
      logic [31:0] prev_addr = 32'd0;
      logic [63:0] prev_data = 64'd0;
      logic        hs_we   [2];
      logic [31:0] hs_addr [2];
      logic [63:0] hs_data [2];

      if (hit) m_hit++; else m_miss++;
      if (dirty) m_wb++;
      while (!req_ready && w < 10) begin
         mem_rvalid = 1'($urandom_range(0, 1));
         step();
         w++;
      end
      mem_rvalid = 1'b0;
      chk_eq("req_ready", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = addr;
      step();
      req_valid = 1'b0;
      req_addr  = $urandom;
      while (!done && n < 200) begin
         chk_eq("req_ready_busy", req_ready, 0);
         if (mem_req_valid && prev_pending) begin
            chk_eq("mem_we_stable", mem_req_we, prev_we);
            chk_eq("mem_addr_stable", mem_req_addr, prev_addr);
            chk_eq("mem_wdata_stable", mem_wdata, prev_data);
         end
         if (fill_we) begin
            fills++;
            chk_eq("fill_entry", fill_entry, {44'd0, 1'b1, 1'b0, tag});
            chk_eq("fill_data", fill_data, rdata);
            chk_eq("fill_cycle", n, exp_cyc - 1);
            chk_eq("fill_resp_overlap", resp_valid, 0);
         end
         if (resp_valid) begin
            done = 1;
            chk_eq("resp_hit", resp_hit, hit);
            chk_eq("resp_cycle", n, exp_cyc);
            chk_eq("hit_cnt", hit_cnt, sat(m_hit));
            chk_eq("miss_cnt", miss_cnt, sat(m_miss));
            chk_eq("wb_cnt", wb_cnt, sat(m_wb));
         end
         if (abort && rv_wait == 2) begin
            // synchronous reset while waiting for read data
            rst = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
            step();
            chk_eq("abort_mem_req_valid", mem_req_valid, 0);
            chk_eq("abort_fill_we", fill_we, 0);
            chk_eq("abort_resp_valid", resp_valid, 0);
            chk_eq("abort_miss_cnt", miss_cnt, 0);
            rst = 1'b0;
            m_hit = 0; m_miss = 0; m_wb = 0;
            for (int i = 0; i < 3; i++) begin
               step();
               chk_eq("abort_late_fill_we", fill_we, 0);
               chk_eq("abort_late_resp", resp_valid, 0);
               chk_eq("abort_late_mem_valid", mem_req_valid, 0);
            end
            mem_rvalid = 1'b0;
            aborted = 1;
            done = 1;
         end else if (!done) begin
            if (rv_wait < 0) begin
               mem_rvalid = 1'($urandom_range(0, 1));
               mem_rdata  = {$urandom, $urandom};
            end else begin
               mem_rvalid = (rv_wait == rv_lat);
               mem_rdata  = (rv_wait == rv_lat) ? rdata : {$urandom, $urandom};
               rv_wait++;
            end
            cur_lat = (hs == 0 && dirty) ? wb_lat : rd_lat;
            mem_req_ready = mem_req_valid ? (low >= cur_lat) : 1'($urandom_range(0, 1));
            if (mem_req_valid && mem_req_ready) begin
               if (hs < 2) begin
                  hs_we[hs] = mem_req_we;
                  hs_addr[hs] = mem_req_addr;
                  hs_data[hs] = mem_wdata;
               end
               if (!mem_req_we) rv_wait = 0;
               hs++;
               low = 0;
            end else if (mem_req_valid) begin
               low++;
            end
            prev_pending = mem_req_valid && !mem_req_ready;
            prev_we = mem_req_we;
            prev_addr = mem_req_addr;
            prev_data = mem_wdata;
            step();
            n++;
         end
      end
      mem_rvalid = 1'b0;
      mem_req_ready = 1'b0;
      chk_eq("resp_seen", done, 1);
      if (!aborted) begin
         chk_eq("fill_count", fills, hit ? 0 : 1);
         chk_eq("mem_hs_count", hs, hit ? 0 : (dirty ? 2 : 1));
         if (dirty && hs >= 1) begin
            chk_eq("wb_we", hs_we[0], 1);
            chk_eq("wb_addr", hs_addr[0], wb_addr);
            chk_eq("wb_data", hs_data[0], wb_data);
         end
         rd_i = dirty ? 1 : 0;
         if (!hit && hs > rd_i) begin
            chk_eq("rd_we", hs_we[rd_i], 0);
            chk_eq("rd_addr", hs_addr[rd_i], rd_addr);
         end
         if (!hit) begin
            l2_v[idx] = 1'b1;
            l2_d[idx] = 1'b0;
            l2_t[idx] = tag;
            l2_line[idx] = rdata;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         l2_v[i] = 1'b0; l2_d[i] = 1'b0; l2_t[i] = 18'd0; l2_line[i] = 64'd0;
      end
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
      step(); step();
      chk_eq("rst_req_ready", req_ready, 0);
      chk_eq("rst_resp_valid", resp_valid, 0);
      chk_eq("rst_fill_we", fill_we, 0);
      chk_eq("rst_mem_req_valid", mem_req_valid, 0);
      chk_eq("rst_mem_req_addr", mem_req_addr, 0);
      chk_eq("rst_l2_index", l2_index, 0);
      chk_eq("rst_counters", {hit_cnt, miss_cnt, wb_cnt}, 0);
      rst = 1'b0;
      step();
      chk_eq("ready_after_rst", req_ready, 1);

      // hit on a clean valid line
      l2_v[10'h329] = 1'b1; l2_d[10'h329] = 1'b0; l2_t[10'h329] = 18'h12345;
      run_req(32'h12345CA4, 0, 0, 0, 64'd0, 1'b0);
      // clean miss
      l2_v[10'h329] = 1'b0;
      run_req(32'h12345CA4, 0, 0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0);
      // dirty miss
      l2_v[10'h329] = 1'b1; l2_d[10'h329] = 1'b1; l2_t[10'h329] = 18'h00ABC;
      l2_line[10'h329] = 64'h1111;
      run_req(32'h12345CA4, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
      // dirty miss under memory backpressure
      l2_v[10'h329] = 1'b1; l2_d[10'h329] = 1'b1; l2_t[10'h329] = 18'h00ABC;
      l2_line[10'h329] = 64'h2222_3333;
      run_req(32'h12345CA4, 5, 5, 2, 64'h5555_AAAA_5555_AAAA, 1'b0);
      idle(4);
      // reset in RD_WAIT, then a normal request
      l2_v[10'h329] = 1'b0;
      run_req(32'h12345CA4, 0, 0, 10, 64'h9999_8888_7777_6666, 1'b1);
      run_req(32'h12345CA4, 0, 0, 0, 64'h4444_3333_2222_1111, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [INDEX_W-1:0] ix;
         logic [TAG_W-1:0]   tg;
         ix = pick_idx($urandom_range(0, 3));
         tg = pick_tag($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            l2_v[ix] = 1'b1; l2_d[ix] = 1'b1;
            l2_t[ix] = pick_tag($urandom_range(0, 3));
            l2_line[ix] = {$urandom, $urandom};
         end else if ($urandom_range(0, 5) == 0) begin
            l2_v[ix] = 1'b0;
         end
         run_req({2'($urandom_range(0, 3)), tg, ix, 2'($urandom_range(0, 3))},
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 {$urandom, $urandom}, 1'b0);
         if ($urandom_range(0, 3) == 0) idle(2);
      end

      // drive the hit counter into saturation
      l2_v[10'h155] = 1'b1; l2_d[10'h155] = 1'b0; l2_t[10'h155] = 18'h3FFFF;
      for (int i = 0; i < 20; i++) begin
         run_req({2'b00, 18'h3FFFF, 10'h155, 2'b00}, 0, 0, 0, 64'd0, 1'b0);
      end
      chk_eq("hit_cnt_saturated", hit_cnt, 64'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
